// File: rtl/score_text_renderer.sv
// Score box renderer: per-frame double-dabble conversion of the score, then 2-stage glyph pixel pipeline.
// Optional leading-zero blanking when SCORE_LEADING_ZERO_BLANK_EN is defined.
module score_text_renderer #(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 4,
    parameter int X0         = 16,
    parameter int Y0         = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic [SCORE_W-1:0] score,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic [7:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic               pixel_on,
    output logic               busy
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int          MAXV   = pow10(NUM_DIGITS) - 1;
    localparam int          BCD_W  = 4 * NUM_DIGITS;
    localparam int          CNT_W  = $clog2(SCORE_W + 1);
    localparam logic [9:0]  XL     = 10'(X0);
    localparam logic [9:0]  XH     = 10'(X0 + 8 * NUM_DIGITS);
    localparam logic [9:0]  YL     = 10'(Y0);
    localparam logic [9:0]  YH     = 10'(Y0 + 16);

    function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] v);
        if (int'(v) > MAXV) return SCORE_W'(MAXV);
        return v;
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t             state;
    logic [SCORE_W-1:0] bin;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   digits;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            bin    <= '0;
            bcd    <= '0;
            digits <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    bin   <= saturate(score);
                    bcd   <= '0;
                    cnt   <= CNT_W'(SCORE_W);
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= {add3(bcd), bin} << 1;
                    cnt        <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= COMMIT;
                end
                COMMIT: begin
                    digits <= bcd;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [9:0] dx;
    logic [6:0] slot;
    logic [3:0] row;
    logic [2:0] col;
    logic       in_box;
    logic [3:0] digit_sel;

    always_comb begin
        dx        = DrawX - XL;
        slot      = dx[9:3];
        col       = dx[2:0];
        row       = DrawY[3:0] - YL[3:0];
        in_box    = (DrawX >= XL) && (DrawX < XH) && (DrawY >= YL) && (DrawY < YH);
        digit_sel = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (slot == 7'(i)) digit_sel = digits[(NUM_DIGITS-1-i)*4 +: 4];
    end

    logic [2:0] col_p1;
    logic       in_box_p1;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    // A slot is blank while every digit from the MSD down to it is zero; the LSD always shows.
    logic blank_sel;
    logic zero_run;
    logic blank_p1;

    always_comb begin
        blank_sel = 1'b0;
        zero_run  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            zero_run = zero_run & (digits[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
            if (slot == 7'(i)) blank_sel = zero_run && (i != NUM_DIGITS - 1);
        end
    end
`endif

    // Stage 1: glyph address and pixel position; stage 2: glyph bit select
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr  <= 8'd0;
            col_p1    <= 3'd0;
            in_box_p1 <= 1'b0;
            pixel_on  <= 1'b0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            blank_p1  <= 1'b0;
`endif
        end else begin
            rom_addr  <= in_box ? {digit_sel, row} : 8'd0;
            col_p1    <= col;
            in_box_p1 <= in_box;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            blank_p1  <= blank_sel;
            pixel_on  <= in_box_p1 & ~blank_p1 & rom_data[col_p1];
`else
            pixel_on  <= in_box_p1 & rom_data[col_p1];
`endif
        end
    end

endmodule

// File: tb/tb_score_text_renderer.sv
// Directed bench for score_text_renderer: conversion timing, digit addressing, pixel pipeline, reset abort.
// Leading-zero blanking scenarios run only when SCORE_LEADING_ZERO_BLANK_EN is defined.
module tb_score_text_renderer;

    localparam int SCORE_W = 14;
    localparam int X0 = 16;
    localparam int Y0 = 16;

    logic               Clk;
    logic               Reset_n;
    logic               frame_start;
    logic [SCORE_W-1:0] score;
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic [7:0]         rom_addr;
    logic [7:0]         rom_data;
    logic               pixel_on;
    logic               busy;

    int passed;
    int total;

    score_text_renderer #(.SCORE_W(SCORE_W), .NUM_DIGITS(4), .X0(X0), .Y0(Y0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .score(score),
        .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel_on(pixel_on), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; frame_start = 1'b0; score = '0;
        DrawX = 10'd0; DrawY = 10'd0; rom_data = 8'h00;
        step; step;
        total++;
        if (busy !== 1'b0 || pixel_on !== 1'b0 || rom_addr !== 8'h00)
            $display("FAIL reset_state busy=%b pixel_on=%b rom_addr=%h, want 0 0 00", busy, pixel_on, rom_addr);
        else passed++;
        Reset_n = 1'b1;
        step;
    endtask

    task automatic scan_digits(input logic [15:0] exp, input string name);
        logic [7:0] want;
        for (int s = 0; s < 4; s++) begin
            DrawX = 10'(X0 + 8 * s + 3);
            DrawY = 10'(Y0 + 5);
            step;
            want = {exp[(3 - s) * 4 +: 4], 4'h5};
            total++;
            if (rom_addr !== want)
                $display("FAIL %s slot%0d rom_addr=%h want %h", name, s, rom_addr, want);
            else passed++;
        end
    endtask

    task automatic test_convert(input logic [SCORE_W-1:0] sc, input bit inject,
                                input logic [15:0] exp, input string name);
        int n;
        score = sc;
        frame_start = 1'b1;
        step;
        frame_start = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL %s busy_start busy=%b want 1", name, busy);
        else passed++;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (inject && n == 4) begin
                frame_start = 1'b1;
                score = 14'd8888;
            end
            step;
            frame_start = 1'b0;
            n++;
        end
        total++;
        if (n !== 16) $display("FAIL %s busy_cycles got %0d want 16", name, n);
        else passed++;
        scan_digits(exp, name);
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [7:0] rd,
                       input logic exp, input string name);
        DrawX = x; DrawY = y; rom_data = rd;
        step;
        DrawX = 10'd0; DrawY = 10'd0;
        step;
        total++;
        if (pixel_on !== exp) $display("FAIL %s pixel_on=%b want %b", name, pixel_on, exp);
        else passed++;
    endtask

    task automatic test_pixel;
        pix(10'(X0), 10'(Y0), 8'h01, 1'b1, "pix_origin");
        pix(10'(X0 + 1), 10'(Y0), 8'h01, 1'b0, "pix_col1");
        pix(10'(X0 - 1), 10'(Y0), 8'hFF, 1'b0, "pix_left_edge");
        pix(10'(X0), 10'(Y0 + 16), 8'hFF, 1'b0, "pix_bottom_edge");
        pix(10'(X0 + 31), 10'(Y0 + 15), 8'h80, 1'b1, "pix_far_corner");
        pix(10'(X0 + 32), 10'(Y0), 8'hFF, 1'b0, "pix_right_edge");
        DrawX = 10'(X0 + 40); DrawY = 10'(Y0);
        step;
        total++;
        if (rom_addr !== 8'h00) $display("FAIL addr_outside rom_addr=%h want 00", rom_addr);
        else passed++;
    endtask

    task automatic test_reset_mid_shift;
        DrawX = 10'(X0); DrawY = 10'(Y0); rom_data = 8'h01;
        step; step;
        total++;
        if (pixel_on !== 1'b1) $display("FAIL pre_abort_pixel pixel_on=%b want 1", pixel_on);
        else passed++;
        score = 14'd1234;
        frame_start = 1'b1;
        step;
        frame_start = 1'b0;
        repeat (5) step;
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || pixel_on !== 1'b0)
            $display("FAIL abort_async busy=%b pixel_on=%b want 0 0", busy, pixel_on);
        else passed++;
        Reset_n = 1'b1;
        step;
        total++;
        if (busy !== 1'b0) $display("FAIL abort_idle busy=%b want 0", busy);
        else passed++;
        scan_digits(16'h0000, "abort_display");
    endtask

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    task automatic test_blank;
        test_convert(14'd42, 1'b0, 16'h0042, "conv_42");
        for (int s = 0; s < 4; s++)
            pix(10'(X0 + 8 * s), 10'(Y0), 8'hFF, logic'(s >= 2), "blank_42");
        test_convert(14'd0, 1'b0, 16'h0000, "conv_0");
        for (int s = 0; s < 4; s++)
            pix(10'(X0 + 8 * s), 10'(Y0), 8'hFF, logic'(s == 3), "blank_0");
    endtask
`endif

    initial begin
        passed = 0;
        total = 0;
        test_reset;
        test_convert(14'd1234, 1'b0, 16'h1234, "conv_1234");
        test_convert(14'd16383, 1'b0, 16'h9999, "conv_sat");
        test_pixel;
        test_reset_mid_shift;
        test_convert(14'd567, 1'b1, 16'h0567, "conv_back_to_back");
        test_convert(14'd7, 1'b0, 16'h0007, "conv_7");
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        test_blank;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
